video_timing_ctrl: RTL
======================

# video_timing_ctrl

Raster sequencer for the HDMI output path, clocked in the pixel domain. It generates hsync, vsync and blank for the `vga_to_dvi` encoder, along with the current pixel coordinates. It also issues frame-buffer read requests a fixed number of cycles ahead of each active pixel, so pixel data arrives aligned with the display. Start and stop commands take effect only at frame boundaries, so the sink never sees a truncated frame.

## Interface
- p_h_active, 640, active pixels per line
- p_h_front, 16, horizontal front porch (cycles)
- p_h_sync, 96, hsync width (cycles)
- p_h_back, 48, horizontal back porch (cycles)
- p_v_active, 480, active lines per frame
- p_v_front, 10, vertical front porch (lines)
- p_v_sync, 2, vsync width (lines)
- p_v_back, 33, vertical back porch (lines)
- p_sync_pol, 1'b0, asserted level of hsync and vsync (0 = active-low)
- p_fetch_lead, 2, fetch lead in cycles; legal range 1 .. p_h_front+p_h_sync+p_h_back
- i_clk_pixel  in  1  pixel clock, the only clock
- i_rst  in  1  reset, asynchronous, active-high
- i_enable  in  1  run request; sampled every cycle
- o_running  out  1  high while not in IDLE
- o_hsync  out  1  horizontal sync
- o_vsync  out  1  vertical sync
- o_blank  out  1  high outside the active area
- o_x  out  11  current h counter
- o_y  out  10  current v counter
- o_frame_start  out  1  one-cycle pulse at pixel (0,0)
- o_line_start  out  1  one-cycle pulse at h=0 of every line (includes blanked lines)
- o_fetch_valid  out  1  fetch request for pixel (o_fetch_x, o_fetch_y)
- o_fetch_x  out  11  fetch target x
- o_fetch_y  out  10  fetch target y

## Operation
- Line layout: active, then front porch, then sync, then back porch. Frame layout uses the same order. With defaults, H_TOT=800 and V_TOT=525.
- States:
  - IDLE: counters frozen. Outputs are o_blank=1, syncs deasserted, all pulses and fetches 0, o_x=o_y=0.
  - IDLE→RUN when i_enable=1. Counters load h=H_TOT-p_fetch_lead, v=V_TOT-1, so the first fetch leads pixel (0,0) by exactly p_fetch_lead cycles.
  - RUN: h increments every cycle. When h reaches H_TOT-1 it wraps to 0 and v increments; when v reaches V_TOT-1 at that point, v wraps to 0.
  - stop_pending is set on any RUN cycle with i_enable=0. It is sticky and clears only in IDLE.
  - RUN→IDLE on the cycle after the last cycle of a frame (h=H_TOT-1, v=V_TOT-1) if stop_pending is set; otherwise the next frame continues seamlessly.
- Decode, from the h/v counter values:
  - hsync asserted for h in [p_h_active+p_h_front, p_h_active+p_h_front+p_h_sync)
  - vsync asserted for v in the equivalent vertical range
  - blank = (h ≥ p_h_active) or (v ≥ p_v_active)
- Fetch address: (fh, fv) is the position p_fetch_lead cycles ahead of (h, v), including the carry into fv and the wrap at V_TOT.
  - o_fetch_valid = RUN and fh<p_h_active and fv<p_v_active.
  - Fetches that wrap into the next frame (fv wraps to 0 while v=V_TOT-1) are suppressed when stop_pending=1.
- Reset, asynchronous at any time including mid-frame: IDLE, stop_pending=0, all outputs at their IDLE values, no partial pulses afterwards.

## Timing
- All outputs are registered. o_hsync, o_vsync, o_blank, o_frame_start and o_line_start are mutually aligned and describe the pixel at (o_x, o_y).
- Fetch for pixel P is asserted exactly p_fetch_lead cycles before the cycle with (o_x, o_y)=P and o_blank=0.
- Enable to first pixel: i_enable sampled high in IDLE at edge N gives o_running=1 after edge N+1, and o_frame_start at edge N+1+p_fetch_lead.
- Exactly one fetch per active pixel per frame: 307200 with defaults. The sequence is gap-free within a line.
- Enable toggled low then high within one frame still stops at the end of that frame, because stop_pending is sticky. The controller then restarts from IDLE if i_enable is high.

## Test plan
- Reset: assert i_rst mid-line at h=300, v=100 → outputs go to IDLE values immediately, without waiting for a clock edge. After release with i_enable=0, the outputs stay idle.
- Start latency: i_enable=1 from IDLE → o_frame_start 3 cycles after the sampling edge (p_fetch_lead=2). The first o_fetch_valid with (0,0) occurs 2 cycles before it.
- Sync geometry over 2 full frames:
  - hsync low for h 656..751 (96 cycles)
  - vsync low for lines 490..491
  - blank count per frame 112800
  - line_start count per frame 525
  - period 420000 cycles
- Fetch alignment: a bench model delays o_fetch_x/y by p_fetch_lead → matches o_x/o_y on every cycle with o_blank=0, with 307200 fetches per frame. Repeat with p_fetch_lead=1 and 160.
- Stop: drop i_enable at v=200 → the frame completes to h=799, v=524, and no fetch targets frame N+1. o_running falls the next cycle.
- Toggle: i_enable low for 1 cycle at v=10, then high → the frame completes, IDLE is held for 1 cycle, then a restart with the nominal start latency.

Source files
------------

// File: rtl/video_timing_ctrl.sv
// Raster sequencer: h/v counters, sync/blank decode and frame-buffer fetch requests
// issued p_fetch_lead cycles ahead of each active pixel; start/stop only at frame edges.
module video_timing_ctrl #(
  parameter int   p_h_active   = 640,
  parameter int   p_h_front    = 16,
  parameter int   p_h_sync     = 96,
  parameter int   p_h_back     = 48,
  parameter int   p_v_active   = 480,
  parameter int   p_v_front    = 10,
  parameter int   p_v_sync     = 2,
  parameter int   p_v_back     = 33,
  parameter logic p_sync_pol   = 1'b0,
  parameter int   p_fetch_lead = 2
) (
  input  logic        i_clk_pixel,
  input  logic        i_rst,
  input  logic        i_enable,
  output logic        o_running,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_blank,
  output logic [10:0] o_x,
  output logic [9:0]  o_y,
  output logic        o_frame_start,
  output logic        o_line_start,
  output logic        o_fetch_valid,
  output logic [10:0] o_fetch_x,
  output logic [9:0]  o_fetch_y
);

  localparam int H_TOT = p_h_active + p_h_front + p_h_sync + p_h_back;
  localparam int V_TOT = p_v_active + p_v_front + p_v_sync + p_v_back;

  localparam logic [10:0] H_LAST  = 11'(H_TOT - 1);
  localparam logic [10:0] H_START = 11'(H_TOT - p_fetch_lead);
  localparam logic [10:0] HA_C    = 11'(p_h_active);
  localparam logic [10:0] HS_BEG  = 11'(p_h_active + p_h_front);
  localparam logic [10:0] HS_END  = 11'(p_h_active + p_h_front + p_h_sync);
  localparam logic [9:0]  V_LAST  = 10'(V_TOT - 1);
  localparam logic [9:0]  VA_C    = 10'(p_v_active);
  localparam logic [9:0]  VS_BEG  = 10'(p_v_active + p_v_front);
  localparam logic [9:0]  VS_END  = 10'(p_v_active + p_v_front + p_v_sync);
  localparam logic [11:0] LEAD_C  = 12'(p_fetch_lead);
  localparam logic [11:0] HTOT_C  = 12'(H_TOT);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state_q;
  logic        stop_pending_q;
  logic [10:0] h_q;
  logic [9:0]  v_q;

  logic        run, h_last, v_last, stop_now;
  logic [11:0] fh_sum;
  logic        f_carry, f_wrap;
  logic [10:0] fh;
  logic [9:0]  fv;

  logic        running_d, hsync_d, vsync_d, blank_d, frame_start_d, line_start_d;
  logic        fetch_vld_d;
  logic [10:0] x_d, fetch_x_d;
  logic [9:0]  y_d, fetch_y_d;

  logic        running_q, hsync_q, vsync_q, blank_q, frame_start_q, line_start_q;
  logic        fetch_vld_q;
  logic [10:0] x_q, fetch_x_q;
  logic [9:0]  y_q, fetch_y_q;

  always_comb begin
    run      = (state_q == S_RUN);
    h_last   = (h_q == H_LAST);
    v_last   = (v_q == V_LAST);
    // the enable sampled this cycle counts, so a stop decided at the frame edge is honoured
    stop_now = stop_pending_q | ~i_enable;

    fh_sum  = {1'b0, h_q} + LEAD_C;
    f_carry = (fh_sum >= HTOT_C);
    fh      = f_carry ? 11'(fh_sum - HTOT_C) : fh_sum[10:0];
    f_wrap  = f_carry & v_last;
    fv      = f_carry ? (v_last ? 10'd0 : v_q + 10'd1) : v_q;

    running_d     = run;
    hsync_d       = (run && h_q >= HS_BEG && h_q < HS_END) ? p_sync_pol : ~p_sync_pol;
    vsync_d       = (run && v_q >= VS_BEG && v_q < VS_END) ? p_sync_pol : ~p_sync_pol;
    blank_d       = ~run | (h_q >= HA_C) | (v_q >= VA_C);
    frame_start_d = run && (h_q == 11'd0) && (v_q == 10'd0);
    line_start_d  = run && (h_q == 11'd0);
    x_d           = run ? h_q : 11'd0;
    y_d           = run ? v_q : 10'd0;
    fetch_vld_d   = run && (fh < HA_C) && (fv < VA_C) && !(f_wrap && stop_now);
    fetch_x_d     = fetch_vld_d ? fh : 11'd0;
    fetch_y_d     = fetch_vld_d ? fv : 10'd0;
  end

  always_ff @(posedge i_clk_pixel or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= S_IDLE;
      stop_pending_q <= 1'b0;
      h_q            <= 11'd0;
      v_q            <= 10'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          stop_pending_q <= 1'b0;
          if (i_enable) begin
            state_q <= S_RUN;
            h_q     <= H_START;
            v_q     <= V_LAST;
          end
        end
        S_RUN: begin
          stop_pending_q <= stop_now;
          if (h_last) begin
            h_q <= 11'd0;
            if (v_last) begin
              v_q <= 10'd0;
              if (stop_now) state_q <= S_IDLE;
            end else begin
              v_q <= v_q + 10'd1;
            end
          end else begin
            h_q <= h_q + 11'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk_pixel or posedge i_rst) begin
    if (i_rst) begin
      running_q     <= 1'b0;
      hsync_q       <= ~p_sync_pol;
      vsync_q       <= ~p_sync_pol;
      blank_q       <= 1'b1;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
      x_q           <= 11'd0;
      y_q           <= 10'd0;
      fetch_vld_q   <= 1'b0;
      fetch_x_q     <= 11'd0;
      fetch_y_q     <= 10'd0;
    end else begin
      running_q     <= running_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
      x_q           <= x_d;
      y_q           <= y_d;
      fetch_vld_q   <= fetch_vld_d;
      fetch_x_q     <= fetch_x_d;
      fetch_y_q     <= fetch_y_d;
    end
  end

  assign o_running     = running_q;
  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_blank       = blank_q;
  assign o_frame_start = frame_start_q;
  assign o_line_start  = line_start_q;
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_fetch_valid = fetch_vld_q;
  assign o_fetch_x     = fetch_x_q;
  assign o_fetch_y     = fetch_y_q;

endmodule
